// File: rtl/commit_trace_checker_pkg.sv
// Shared types for the commit trace checker: record layout, kind and fail codes,
// checker state encoding, plus helpers to unpack a record and classify a commit.
package trace_chk_pkg;

   localparam int TRACE_REC_W = 55;

   localparam int REC_KIND_LO  = 53;
   localparam int REC_CHK_ADDR = 52;
   localparam int REC_PC_LO    = 36;
   localparam int REC_REG_LO   = 32;
   localparam int REC_VAL_LO   = 16;
   localparam int REC_ADDR_LO  = 0;

   typedef enum logic [1:0] {
      KIND_NOP  = 2'd0,
      KIND_REG  = 2'd1,
      KIND_ST   = 2'd2,
      KIND_HALT = 2'd3
   } kind_e;

   typedef enum logic [2:0] {
      FC_NONE    = 3'd0,
      FC_KIND    = 3'd1,
      FC_PC      = 3'd2,
      FC_REG     = 3'd3,
      FC_VALUE   = 3'd4,
      FC_ADDR    = 3'd5,
      FC_TIMEOUT = 3'd6,
      FC_OVERRUN = 3'd7
   } fail_code_e;

   typedef enum logic [1:0] {
      ST_PRIME     = 2'd0,
      ST_RUN       = 2'd1,
      ST_DONE_PASS = 2'd2,
      ST_DONE_FAIL = 2'd3
   } chk_state_e;

   typedef struct packed {
      kind_e       kind;
      logic        chk_addr;
      logic [15:0] pc;
      logic [3:0]  rg;
      logic [15:0] val;
      logic [15:0] addr;
   } trace_rec_t;

   function automatic trace_rec_t rec_unpack(input logic [TRACE_REC_W-1:0] r);
      trace_rec_t t;
      t.kind     = kind_e'(r[REC_KIND_LO +: 2]);
      t.chk_addr = r[REC_CHK_ADDR];
      t.pc       = r[REC_PC_LO +: 16];
      t.rg       = r[REC_REG_LO +: 4];
      t.val      = r[REC_VAL_LO +: 16];
      t.addr     = r[REC_ADDR_LO +: 16];
      return t;
   endfunction

   // A commit that writes a register is REG even if it also halts or stores.
   function automatic kind_e classify(input logic reg_we, input logic halt, input logic mem_we);
      if (reg_we)      return KIND_REG;
      else if (halt)   return KIND_HALT;
      else if (mem_we) return KIND_ST;
      else             return KIND_NOP;
   endfunction

endpackage

// File: rtl/commit_trace_checker_compare.sv
// Combinational comparison of one retired commit against one expected-trace record;
// reports the first diverging field in fixed priority order.
module commit_compare
   import trace_chk_pkg::*;
(
   input  logic [15:0]            i_pc,
   input  logic                   i_reg_we,
   input  logic [3:0]             i_reg,
   input  logic [15:0]            i_reg_data,
   input  logic                   i_mem_re,
   input  logic                   i_mem_we,
   input  logic [15:0]            i_mem_addr,
   input  logic [15:0]            i_mem_data,
   input  logic                   i_halt,
   input  logic [TRACE_REC_W-1:0] i_rec,
   output logic                   o_match,
   output logic [2:0]             o_fail_code,
   output logic                   o_rec_halt
);

   trace_rec_t w_rec;
   kind_e      w_kind;
   fail_code_e w_code;

   always_comb begin
      w_rec  = rec_unpack(i_rec);
      w_kind = classify(i_reg_we, i_halt, i_mem_we);
      w_code = FC_NONE;
      if (w_kind != w_rec.kind)
         w_code = FC_KIND;
      else if (i_pc != w_rec.pc)
         w_code = FC_PC;
      else if (w_kind == KIND_REG && i_reg != w_rec.rg)
         w_code = FC_REG;
      else if ((w_kind == KIND_REG && i_reg_data != w_rec.val) ||
               (w_kind == KIND_ST  && i_mem_data != w_rec.val))
         w_code = FC_VALUE;
      // A REG record with chk_addr describes a load, so the commit must actually read.
      else if ((w_kind == KIND_ST && i_mem_addr != w_rec.addr) ||
               (w_kind == KIND_REG && w_rec.chk_addr &&
                (!i_mem_re || i_mem_addr != w_rec.addr)))
         w_code = FC_ADDR;
   end

   assign o_fail_code = w_code;
   assign o_match     = (w_code == FC_NONE);
   assign o_rec_halt  = (w_rec.kind == KIND_HALT);

endmodule

// File: rtl/commit_trace_checker.sv
// Replays an expected-trace image from a synchronous memory and checks every
// retired commit against it, one record per commit with zero-bubble prefetch.
//
// state        | meaning
// ST_PRIME     | fetching record 0 before the cpu is released
// ST_RUN       | checking commits, prefetching the next record on each match
// ST_DONE_PASS | HALT record matched; absorbing until reset
// ST_DONE_FAIL | divergence, timeout or overrun; absorbing until reset
module commit_trace_checker
   import trace_chk_pkg::*;
#(
   parameter int ADDR_W     = 12,
   parameter int MAX_CYCLES = 100000,
   parameter int REC_W      = 55
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cm_valid,
   input  logic [15:0]       cm_pc,
   input  logic              cm_reg_we,
   input  logic [3:0]        cm_reg,
   input  logic [15:0]       cm_reg_data,
   input  logic              cm_mem_re,
   input  logic              cm_mem_we,
   input  logic [15:0]       cm_mem_addr,
   input  logic [15:0]       cm_mem_data,
   input  logic              cm_halt,
   output logic              exp_rd_en,
   output logic [ADDR_W-1:0] exp_addr,
   input  logic [REC_W-1:0]  exp_rec,
   output logic              chk_ready,
   output logic              done,
   output logic              pass,
   output logic              fail,
   output logic [2:0]        fail_code,
   output logic [15:0]       fail_inum,
   output logic [15:0]       inst_count,
   output logic [16:0]       cycle_count
);

   if (REC_W != TRACE_REC_W) begin : g_rec_w_check
      $error("REC_W must equal trace_chk_pkg::TRACE_REC_W");
   end

   localparam logic [16:0] CYC_LIMIT = 17'(MAX_CYCLES);

   chk_state_e        r_state;
   chk_state_e        w_state_nxt;
   logic [ADDR_W-1:0] r_idx;
   logic [15:0]       r_inst_count;
   logic [16:0]       r_cycle_count;
   logic [2:0]        r_fail_code;
   logic [15:0]       r_fail_inum;

   logic              w_match;
   logic [2:0]        w_cmp_code;
   logic              w_rec_halt;
   logic              w_last;
   logic [16:0]       w_cyc_inc;
   logic              w_timeout;
   logic              w_rd_en;
   logic [ADDR_W-1:0] w_addr;
   logic              w_advance;
   logic              w_count;
   logic              w_fail_set;
   logic [2:0]        w_fail_code_nxt;

   commit_compare u_compare (
      .i_pc        (cm_pc),
      .i_reg_we    (cm_reg_we),
      .i_reg       (cm_reg),
      .i_reg_data  (cm_reg_data),
      .i_mem_re    (cm_mem_re),
      .i_mem_we    (cm_mem_we),
      .i_mem_addr  (cm_mem_addr),
      .i_mem_data  (cm_mem_data),
      .i_halt      (cm_halt),
      .i_rec       (exp_rec),
      .o_match     (w_match),
      .o_fail_code (w_cmp_code),
      .o_rec_halt  (w_rec_halt)
   );

   assign w_last    = (r_idx == {ADDR_W{1'b1}});
   assign w_cyc_inc = (r_cycle_count == 17'h1_FFFF) ? r_cycle_count : r_cycle_count + 17'd1;
   assign w_timeout = (w_cyc_inc >= CYC_LIMIT);

   always_comb begin
      w_state_nxt     = r_state;
      w_rd_en         = 1'b0;
      w_addr          = r_idx;
      w_advance       = 1'b0;
      w_count         = 1'b0;
      w_fail_set      = 1'b0;
      w_fail_code_nxt = FC_NONE;
      case (r_state)
         ST_PRIME: begin
            w_rd_en     = 1'b1;
            w_addr      = '0;
            w_state_nxt = ST_RUN;
         end
         ST_RUN: begin
            if (cm_valid && !w_match) begin
               w_fail_set      = 1'b1;
               w_fail_code_nxt = w_cmp_code;
            end else if (cm_valid && w_rec_halt) begin
               w_count     = 1'b1;
               w_state_nxt = ST_DONE_PASS;
            end else if (cm_valid && w_last) begin
               // No record beyond the image; refuse to wrap back to record 0.
               w_count         = 1'b1;
               w_fail_set      = 1'b1;
               w_fail_code_nxt = FC_OVERRUN;
            end else begin
               if (cm_valid) begin
                  w_count   = 1'b1;
                  w_advance = 1'b1;
                  w_addr    = r_idx + ADDR_W'(1);
                  w_rd_en   = !w_timeout;
               end
               if (w_timeout) begin
                  w_fail_set      = 1'b1;
                  w_fail_code_nxt = FC_TIMEOUT;
               end
            end
            if (w_fail_set) w_state_nxt = ST_DONE_FAIL;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state       <= ST_PRIME;
         r_idx         <= '0;
         r_inst_count  <= '0;
         r_cycle_count <= '0;
         r_fail_code   <= '0;
         r_fail_inum   <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == ST_RUN) r_cycle_count <= w_cyc_inc;
         if (w_count)   r_inst_count <= r_inst_count + 16'd1;
         if (w_advance) r_idx <= r_idx + ADDR_W'(1);
         if (w_fail_set) begin
            r_fail_code <= w_fail_code_nxt;
            r_fail_inum <= 16'(r_idx);
         end
      end
   end

   // Memory stays idle while reset is held so the image is not touched mid-reset.
   assign exp_rd_en   = w_rd_en & rst_n;
   assign exp_addr    = rst_n ? w_addr : '0;
   assign chk_ready   = (r_state != ST_PRIME);
   assign done        = (r_state == ST_DONE_PASS) || (r_state == ST_DONE_FAIL);
   assign pass        = (r_state == ST_DONE_PASS);
   assign fail        = (r_state == ST_DONE_FAIL);
   assign fail_code   = r_fail_code;
   assign fail_inum   = r_fail_inum;
   assign inst_count  = r_inst_count;
   assign cycle_count = r_cycle_count;

endmodule

// File: tb/tb_commit_trace_checker.sv
// Directed bench for commit_trace_checker: a table of commit vectors with hand-computed
// results applied to a default-size and a small (ADDR_W=2, MAX_CYCLES=20) instance.
module tb_commit_trace_checker;
   import trace_chk_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        cm_valid, cm_reg_we, cm_mem_re, cm_mem_we, cm_halt;
   logic [15:0] cm_pc, cm_reg_data, cm_mem_addr, cm_mem_data;
   logic [3:0]  cm_reg;

   logic        rd_en_b, ready_b, done_b, pass_b, fail_b;
   logic [11:0] addr_b;
   logic [54:0] rec_b;
   logic [2:0]  code_b;
   logic [15:0] inum_b, icnt_b;
   logic [16:0] cyc_b;

   logic        rd_en_s, ready_s, done_s, pass_s, fail_s;
   logic [1:0]  addr_s;
   logic [54:0] rec_s;
   logic [2:0]  code_s;
   logic [15:0] inum_s, icnt_s;
   logic [16:0] cyc_s;

   logic [54:0] mem_b [0:4095];
   logic [54:0] mem_s [0:3];

   always @(posedge clk) if (rd_en_b) rec_b <= mem_b[addr_b];
   always @(posedge clk) if (rd_en_s) rec_s <= mem_s[addr_s];

   commit_trace_checker u_big (
      .clk(clk), .rst_n(rst_n), .cm_valid(cm_valid), .cm_pc(cm_pc), .cm_reg_we(cm_reg_we),
      .cm_reg(cm_reg), .cm_reg_data(cm_reg_data), .cm_mem_re(cm_mem_re), .cm_mem_we(cm_mem_we),
      .cm_mem_addr(cm_mem_addr), .cm_mem_data(cm_mem_data), .cm_halt(cm_halt),
      .exp_rd_en(rd_en_b), .exp_addr(addr_b), .exp_rec(rec_b), .chk_ready(ready_b),
      .done(done_b), .pass(pass_b), .fail(fail_b), .fail_code(code_b), .fail_inum(inum_b),
      .inst_count(icnt_b), .cycle_count(cyc_b)
   );

   commit_trace_checker #(.ADDR_W(2), .MAX_CYCLES(20), .REC_W(55)) u_small (
      .clk(clk), .rst_n(rst_n), .cm_valid(cm_valid), .cm_pc(cm_pc), .cm_reg_we(cm_reg_we),
      .cm_reg(cm_reg), .cm_reg_data(cm_reg_data), .cm_mem_re(cm_mem_re), .cm_mem_we(cm_mem_we),
      .cm_mem_addr(cm_mem_addr), .cm_mem_data(cm_mem_data), .cm_halt(cm_halt),
      .exp_rd_en(rd_en_s), .exp_addr(addr_s), .exp_rec(rec_s), .chk_ready(ready_s),
      .done(done_s), .pass(pass_s), .fail(fail_s), .fail_code(code_s), .fail_inum(inum_s),
      .inst_count(icnt_s), .cycle_count(cyc_s)
   );

   typedef struct {
      bit          first;
      int          img;
      logic        v;
      logic [15:0] pc;
      logic        rwe;
      logic [3:0]  rg;
      logic [15:0] rd;
      logic        mre;
      logic        mwe;
      logic [15:0] ma;
      logic [15:0] md;
      logic        h;
      logic        e_done;
      logic        e_pass;
      logic        e_fail;
      logic [2:0]  e_code;
      logic [15:0] e_inum;
      logic [15:0] e_icnt;
      logic [16:0] e_cyc;
      int          e_rden;   // -1: not checked
   } vec_t;

   vec_t tbl[$];
   vec_t va[4];
   int   total = 0;
   int   bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [54:0] mk_rec(input logic [1:0] k, input logic ca, input logic [15:0] pc,
                                          input logic [3:0] rg, input logic [15:0] val, input logic [15:0] addr);
      return {k, ca, pc, rg, val, addr};
   endfunction

   function automatic vec_t mkv(input bit first, input int img, input logic v, input logic [15:0] pc,
                                input logic rwe, input logic [3:0] rg, input logic [15:0] rd,
                                input logic mre, input logic mwe, input logic [15:0] ma, input logic [15:0] md,
                                input logic h, input logic ed, input logic ep, input logic ef, input logic [2:0] ec,
                                input logic [15:0] ei, input logic [15:0] ecnt, input logic [16:0] ecyc, input int erd);
      vec_t t;
      t.first = first; t.img = img; t.v = v; t.pc = pc; t.rwe = rwe; t.rg = rg; t.rd = rd;
      t.mre = mre; t.mwe = mwe; t.ma = ma; t.md = md; t.h = h;
      t.e_done = ed; t.e_pass = ep; t.e_fail = ef; t.e_code = ec; t.e_inum = ei;
      t.e_icnt = ecnt; t.e_cyc = ecyc; t.e_rden = erd;
      return t;
   endfunction

   task automatic load_image(input int id);
      logic [54:0] img [4];
      for (int i = 0; i < 4; i++) img[i] = '0;
      case (id)
         0: begin
            img[0] = mk_rec(KIND_REG, 1'b0, 16'd0, 4'd1, 16'h0005, 16'h0000);
            img[1] = mk_rec(KIND_ST, 1'b0, 16'd1, 4'd0, 16'h0005, 16'h0010);
            img[2] = mk_rec(KIND_NOP, 1'b0, 16'd2, 4'd0, 16'h0000, 16'h0000);
            img[3] = mk_rec(KIND_HALT, 1'b0, 16'd3, 4'd0, 16'h0000, 16'h0000);
         end
         1: begin
            img[0] = mk_rec(KIND_REG, 1'b0, 16'd0, 4'd1, 16'h0005, 16'h0000);
            img[1] = mk_rec(KIND_ST, 1'b0, 16'd1, 4'd0, 16'h0005, 16'h0010);
            img[2] = mk_rec(KIND_HALT, 1'b0, 16'd2, 4'd0, 16'h0000, 16'h0000);
            img[3] = mk_rec(KIND_HALT, 1'b0, 16'd3, 4'd0, 16'h0000, 16'h0000);
         end
         2: begin
            img[0] = mk_rec(KIND_REG, 1'b1, 16'd0, 4'd2, 16'h1234, 16'h0020);
            img[1] = mk_rec(KIND_HALT, 1'b0, 16'd1, 4'd0, 16'h0000, 16'h0000);
         end
         3: begin
            img[0] = mk_rec(KIND_NOP, 1'b0, 16'h0100, 4'd0, 16'h0000, 16'h0000);
            img[1] = mk_rec(KIND_HALT, 1'b0, 16'h0101, 4'd0, 16'h0000, 16'h0000);
         end
         default: begin
            for (int i = 0; i < 4; i++) img[i] = mk_rec(KIND_NOP, 1'b0, 16'(i), 4'd0, 16'h0000, 16'h0000);
         end
      endcase
      for (int i = 0; i < 4096; i++) mem_b[i] = '0;
      for (int i = 0; i < 4; i++) begin
         mem_b[i] = img[i];
         mem_s[i] = img[i];
      end
   endtask

   task automatic clear_inputs();
      cm_valid = 1'b0; cm_pc = '0; cm_reg_we = 1'b0; cm_reg = '0; cm_reg_data = '0;
      cm_mem_re = 1'b0; cm_mem_we = 1'b0; cm_mem_addr = '0; cm_mem_data = '0; cm_halt = 1'b0;
   endtask

   task automatic do_reset(input int img);
      @(negedge clk);
      rst_n = 1'b0;
      clear_inputs();
      load_image(img);
      @(posedge clk);
      #1;
      chk("rst_rd_en", rd_en_b, 0);   chk("rst_addr", addr_b, 0);   chk("rst_ready", ready_b, 0);
      chk("rst_done", done_b, 0);     chk("rst_pass", pass_b, 0);   chk("rst_fail", fail_b, 0);
      chk("rst_code", code_b, 0);     chk("rst_inum", inum_b, 0);   chk("rst_icnt", icnt_b, 0);
      chk("rst_cyc", cyc_b, 0);       chk("rst_fail_s", fail_s, 0); chk("rst_cyc_s", cyc_s, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("prime_rd_en", rd_en_b, 1); chk("prime_addr", addr_b, 0); chk("prime_ready", ready_b, 0);
   endtask

   task automatic step(input vec_t t, input string tag);
      @(negedge clk);
      cm_valid = t.v; cm_pc = t.pc; cm_reg_we = t.rwe; cm_reg = t.rg; cm_reg_data = t.rd;
      cm_mem_re = t.mre; cm_mem_we = t.mwe; cm_mem_addr = t.ma; cm_mem_data = t.md; cm_halt = t.h;
      #1;
      if (t.e_rden >= 0) begin
         chk({tag, "_rd_en"}, rd_en_b, t.e_rden);
         chk({tag, "_rd_en_s"}, rd_en_s, t.e_rden);
      end
      @(posedge clk);
      #1;
      chk({tag, "_ready"}, ready_b, 1);
      chk({tag, "_done"}, done_b, t.e_done);   chk({tag, "_done_s"}, done_s, t.e_done);
      chk({tag, "_pass"}, pass_b, t.e_pass);   chk({tag, "_pass_s"}, pass_s, t.e_pass);
      chk({tag, "_fail"}, fail_b, t.e_fail);   chk({tag, "_fail_s"}, fail_s, t.e_fail);
      chk({tag, "_code"}, code_b, t.e_code);   chk({tag, "_code_s"}, code_s, t.e_code);
      chk({tag, "_inum"}, inum_b, t.e_inum);   chk({tag, "_inum_s"}, inum_s, t.e_inum);
      chk({tag, "_icnt"}, icnt_b, t.e_icnt);   chk({tag, "_icnt_s"}, icnt_s, t.e_icnt);
      chk({tag, "_cyc"}, cyc_b, t.e_cyc);      chk({tag, "_cyc_s"}, cyc_s, t.e_cyc);
   endtask

   task automatic nop_cycle(input logic v, input logic [15:0] pc);
      @(negedge clk);
      clear_inputs();
      cm_valid = v;
      cm_pc = pc;
      @(posedge clk);
      #1;
   endtask

   initial begin
      clear_inputs();
      //              first img v  pc      rwe rg  rd        mre mwe ma        md        h   | d p f code inum icnt cyc rden
      va[0] = mkv(1, 0, 1, 16'd0, 1, 4'd1, 16'h0005, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 3'd0, 16'd0, 16'd1, 17'd1, 1);
      va[1] = mkv(0, 0, 1, 16'd1, 0, 4'd0, 16'h0000, 0, 1, 16'h0010, 16'h0005, 0, 0, 0, 0, 3'd0, 16'd0, 16'd2, 17'd2, 1);
      va[2] = mkv(0, 0, 1, 16'd2, 0, 4'd0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 3'd0, 16'd0, 16'd3, 17'd3, 1);
      va[3] = mkv(0, 0, 1, 16'd3, 0, 4'd0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 1, 1, 0, 3'd0, 16'd0, 16'd4, 17'd4, -1);

      // full matching run, then a commit after DONE is ignored
      for (int i = 0; i < 4; i++) tbl.push_back(va[i]);
      tbl.push_back(mkv(0, 0, 1, 16'd9, 1, 4'd3, 16'h7777, 0, 0, 16'h0000, 16'h0000, 0, 1, 1, 0, 3'd0, 16'd0, 16'd4, 17'd4, 0));
      // store data diverges at commit 1
      tbl.push_back(va[0]);
      tbl.push_back(mkv(0, 0, 1, 16'd1, 0, 4'd0, 16'h0000, 0, 1, 16'h0010, 16'h0006, 0, 1, 0, 1, 3'd4, 16'd1, 16'd1, 17'd2, 0));
      tbl.push_back(mkv(0, 0, 1, 16'd2, 0, 4'd0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 1, 0, 1, 3'd4, 16'd1, 16'd1, 17'd2, 0));
      // pc, reg, value and kind mismatches on the first commit
      tbl.push_back(mkv(1, 0, 1, 16'd7, 1, 4'd1, 16'h0005, 0, 0, 16'h0000, 16'h0000, 0, 1, 0, 1, 3'd2, 16'd0, 16'd0, 17'd1, 0));
      tbl.push_back(mkv(1, 0, 1, 16'd0, 1, 4'd2, 16'h0005, 0, 0, 16'h0000, 16'h0000, 0, 1, 0, 1, 3'd3, 16'd0, 16'd0, 17'd1, 0));
      tbl.push_back(mkv(1, 0, 1, 16'd0, 1, 4'd1, 16'h0006, 0, 0, 16'h0000, 16'h0000, 0, 1, 0, 1, 3'd4, 16'd0, 16'd0, 17'd1, 0));
      tbl.push_back(mkv(1, 0, 1, 16'd0, 0, 4'd0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 1, 0, 1, 3'd1, 16'd0, 16'd0, 17'd1, 0));
      // store address mismatch
      tbl.push_back(va[0]);
      tbl.push_back(mkv(0, 0, 1, 16'd1, 0, 4'd0, 16'h0000, 0, 1, 16'h0011, 16'h0005, 0, 1, 0, 1, 3'd5, 16'd1, 16'd1, 17'd2, 0));
      // load address checks: wrong address, missing mem_re, then a correct load
      tbl.push_back(mkv(1, 2, 1, 16'd0, 1, 4'd2, 16'h1234, 1, 0, 16'h0022, 16'h0000, 0, 1, 0, 1, 3'd5, 16'd0, 16'd0, 17'd1, 0));
      tbl.push_back(mkv(1, 2, 1, 16'd0, 1, 4'd2, 16'h1234, 0, 0, 16'h0020, 16'h0000, 0, 1, 0, 1, 3'd5, 16'd0, 16'd0, 17'd1, 0));
      tbl.push_back(mkv(1, 2, 1, 16'd0, 1, 4'd2, 16'h1234, 1, 0, 16'h0020, 16'h0000, 0, 0, 0, 0, 3'd0, 16'd0, 16'd1, 17'd1, 1));
      tbl.push_back(mkv(0, 2, 1, 16'd1, 0, 4'd0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 1, 1, 0, 3'd0, 16'd0, 16'd2, 17'd2, -1));
      // reg_we together with halt against a HALT record classifies as REG
      tbl.push_back(mkv(1, 1, 1, 16'd0, 1, 4'd1, 16'h0005, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 3'd0, 16'd0, 16'd1, 17'd1, 1));
      tbl.push_back(mkv(0, 1, 1, 16'd1, 0, 4'd0, 16'h0000, 0, 1, 16'h0010, 16'h0005, 0, 0, 0, 0, 3'd0, 16'd0, 16'd2, 17'd2, 1));
      tbl.push_back(mkv(0, 1, 1, 16'd2, 1, 4'd1, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 1, 0, 1, 3'd1, 16'd2, 16'd2, 17'd3, 0));
      // commit gaps: valid 1,0,0,1
      tbl.push_back(mkv(1, 3, 1, 16'h0100, 0, 4'd0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 3'd0, 16'd0, 16'd1, 17'd1, 1));
      tbl.push_back(mkv(0, 3, 0, 16'h0000, 0, 4'd0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 3'd0, 16'd0, 16'd1, 17'd2, 0));
      tbl.push_back(mkv(0, 3, 0, 16'h0000, 0, 4'd0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 3'd0, 16'd0, 16'd1, 17'd3, 0));
      tbl.push_back(mkv(0, 3, 1, 16'h0101, 0, 4'd0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 1, 1, 0, 3'd0, 16'd0, 16'd2, 17'd4, -1));

      for (int i = 0; i < tbl.size(); i++) begin
         if (tbl[i].first) do_reset(tbl[i].img);
         step(tbl[i], $sformatf("t%0d", i));
      end

      // timeout on the small instance at cycle 20
      do_reset(4);
      nop_cycle(1'b1, 16'd0);
      nop_cycle(1'b1, 16'd1);
      repeat (17) nop_cycle(1'b0, 16'd0);
      chk("to_cyc19", cyc_s, 19);
      chk("to_done19", done_s, 0);
      nop_cycle(1'b0, 16'd0);
      chk("to_fail", fail_s, 1);
      chk("to_code", code_s, 6);
      chk("to_cyc", cyc_s, 20);
      chk("to_inum", inum_s, 2);
      chk("to_icnt", icnt_s, 2);
      chk("to_big_done", done_b, 0);
      chk("to_big_cyc", cyc_b, 20);
      nop_cycle(1'b0, 16'd0);
      chk("to_cyc_hold", cyc_s, 20);
      chk("to_big_cyc21", cyc_b, 21);

      // mismatch in the timeout cycle takes precedence
      do_reset(4);
      nop_cycle(1'b1, 16'd0);
      nop_cycle(1'b1, 16'd1);
      repeat (17) nop_cycle(1'b0, 16'd0);
      chk("prec_done19", done_s, 0);
      nop_cycle(1'b1, 16'h0055);
      chk("prec_code", code_s, 2);
      chk("prec_cyc", cyc_s, 20);
      chk("prec_inum", inum_s, 2);
      chk("prec_big_code", code_b, 2);

      // overrun past the last record of the small image
      do_reset(4);
      for (int i = 0; i < 3; i++) nop_cycle(1'b1, 16'(i));
      @(negedge clk);
      clear_inputs();
      cm_valid = 1'b1;
      cm_pc = 16'd3;
      #1;
      chk("ovr_rd_en_s", rd_en_s, 0);
      chk("ovr_rd_en_b", rd_en_b, 1);
      chk("ovr_addr_b", addr_b, 4);
      @(posedge clk);
      #1;
      chk("ovr_fail", fail_s, 1);
      chk("ovr_code", code_s, 7);
      chk("ovr_inum", inum_s, 3);
      chk("ovr_big_done", done_b, 0);
      chk("ovr_big_icnt", icnt_b, 4);

      // reset mid-run clears everything and replays from record 0
      do_reset(0);
      step(va[0], "mr_a0");
      step(va[1], "mr_a1");
      do_reset(0);
      for (int i = 0; i < 4; i++) step(va[i], $sformatf("mr_b%0d", i));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
